// File: rtl/gx4000_cpr_parser.sv
// Streaming CPR (RIFF/AMS!) cartridge image parser: validates the container, walks chunks
// and writes cbNN bank payloads to cartridge ROM with bank-relative addresses.
module gx4000_cpr_parser #(
    parameter int MAX_BANKS = 32,
    parameter int BANK_AW   = 14,
    parameter int BANK_BITS = 5,
    parameter int CSUM_W    = 16
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          file_load,
    input  logic                          file_wr,
    input  logic [24:0]                   file_addr,
    input  logic [7:0]                    file_data,
    output logic                          rom_wr,
    output logic [BANK_BITS+BANK_AW-1:0]  rom_addr,
    output logic [7:0]                    rom_data,
    output logic [MAX_BANKS-1:0]          bank_valid,
    output logic [BANK_BITS:0]            bank_count,
    output logic [CSUM_W-1:0]             payload_checksum,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [2:0]                    err_code,
    output logic                          warn_oversize
);

    typedef enum logic [3:0] {
        S_IDLE, S_RIFF_ID, S_RIFF_LEN, S_FORM_ID, S_CHK_ID,
        S_CHK_LEN, S_CHK_DATA, S_CHK_SKIP, S_CHK_PAD, S_ERR
    } state_t;

    // Bank numbers are at most 99, so the limit is clamped to fit the 8-bit decode.
    localparam logic [7:0] BANK_LIMIT = (MAX_BANKS > 100) ? 8'd100 : 8'(MAX_BANKS);

    function automatic logic [7:0] riff_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h52;
            2'd1:    b = 8'h49;
            2'd2:    b = 8'h46;
            2'd3:    b = 8'h46;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] ams_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h41;
            2'd1:    b = 8'h4D;
            2'd2:    b = 8'h53;
            2'd3:    b = 8'h21;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t               state_r;
    logic                 load_d_r;
    logic [24:0]          exp_addr_r;
    logic [1:0]           cnt_r;
    logic [31:0]          id_r;
    logic [31:0]          len_r;
    logic [31:0]          rem_r;
    logic [BANK_AW:0]     off_r;
    logic [BANK_BITS-1:0] bank_r;

    logic        load_rise_s;
    logic        load_fall_s;
    logic        take_s;
    state_t      st_s;
    logic [24:0] exp_s;
    logic [1:0]  cnt_s;
    logic [2:0]  fail_code_s;
    logic [31:0] len_full_s;
    logic [7:0]  d1_s;
    logic [7:0]  d0_s;
    logic [7:0]  bank_num_s;
    logic        is_bank_s;
    state_t      after_len_s;
    state_t      after_body_s;

    // A rising file_load makes the byte of that same cycle the first byte of a fresh file.
    always_comb begin
        load_rise_s = file_load & ~load_d_r;
        load_fall_s = ~file_load & load_d_r;
        if (load_rise_s) begin
            st_s  = S_RIFF_ID;
            exp_s = 25'd0;
            cnt_s = 2'd0;
        end else begin
            st_s  = state_r;
            exp_s = exp_addr_r;
            cnt_s = cnt_r;
        end
        take_s = file_load & file_wr & (st_s != S_IDLE) & (st_s != S_ERR);
    end

    // Per-byte error classification; the address check takes priority over signatures.
    always_comb begin
        fail_code_s = 3'd0;
        if (!take_s) begin
            fail_code_s = 3'd0;
        end else if (file_addr != exp_s) begin
            fail_code_s = 3'd3;
        end else if ((st_s == S_RIFF_ID) && (file_data != riff_byte(cnt_s))) begin
            fail_code_s = 3'd1;
        end else if ((st_s == S_FORM_ID) && (file_data != ams_byte(cnt_s))) begin
            fail_code_s = 3'd2;
        end else begin
            fail_code_s = 3'd0;
        end
    end

    // Chunk classification, evaluated while the last length byte arrives (id_r is complete).
    always_comb begin
        len_full_s = {file_data, len_r[31:8]};
        d1_s       = id_r[15:8] - 8'h30;
        d0_s       = id_r[7:0] - 8'h30;
        bank_num_s = d1_s * 8'd10 + d0_s;
        is_bank_s  = (id_r[31:16] == 16'h6362) &&
                     (id_r[15:8] >= 8'h30) && (id_r[15:8] <= 8'h39) &&
                     (id_r[7:0] >= 8'h30) && (id_r[7:0] <= 8'h39) &&
                     (bank_num_s < BANK_LIMIT);
        if (len_full_s == 32'd0) begin
            after_len_s = S_CHK_ID;
        end else if (is_bank_s) begin
            after_len_s = S_CHK_DATA;
        end else begin
            after_len_s = S_CHK_SKIP;
        end
        if (len_r[0]) begin
            after_body_s = S_CHK_PAD;
        end else begin
            after_body_s = S_CHK_ID;
        end
    end

    // Parser state machine, ROM write port and status outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r          <= S_IDLE;
            load_d_r         <= 1'b0;
            exp_addr_r       <= 25'd0;
            cnt_r            <= 2'd0;
            id_r             <= 32'd0;
            len_r            <= 32'd0;
            rem_r            <= 32'd0;
            off_r            <= '0;
            bank_r           <= '0;
            rom_wr           <= 1'b0;
            rom_addr         <= '0;
            rom_data         <= 8'd0;
            bank_valid       <= '0;
            bank_count       <= '0;
            payload_checksum <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_code         <= 3'd0;
            warn_oversize    <= 1'b0;
        end else begin
            load_d_r <= file_load;
            rom_wr   <= 1'b0;

            if (load_rise_s) begin
                state_r          <= S_RIFF_ID;
                exp_addr_r       <= 25'd0;
                cnt_r            <= 2'd0;
                bank_valid       <= '0;
                bank_count       <= '0;
                payload_checksum <= '0;
                busy             <= 1'b1;
                done             <= 1'b0;
                error            <= 1'b0;
                err_code         <= 3'd0;
                warn_oversize    <= 1'b0;
            end else if (load_fall_s) begin
                if ((state_r == S_CHK_ID) && (cnt_r == 2'd0)) begin
                    done    <= 1'b1;
                    state_r <= S_IDLE;
                end else if ((state_r != S_ERR) && (state_r != S_IDLE)) begin
                    state_r  <= S_ERR;
                    error    <= 1'b1;
                    err_code <= 3'd4;
                end
                busy <= 1'b0;
            end

            if (take_s) begin
                if (fail_code_s != 3'd0) begin
                    state_r  <= S_ERR;
                    error    <= 1'b1;
                    err_code <= fail_code_s;
                    busy     <= 1'b0;
                end else begin
                    exp_addr_r <= exp_s + 25'd1;
                    cnt_r      <= cnt_s + 2'd1;
                    case (st_s)
                        S_RIFF_ID: begin
                            if (cnt_s == 2'd3) state_r <= S_RIFF_LEN;
                        end
                        S_RIFF_LEN: begin
                            len_r <= len_full_s;
                            if (cnt_s == 2'd3) state_r <= S_FORM_ID;
                        end
                        S_FORM_ID: begin
                            if (cnt_s == 2'd3) state_r <= S_CHK_ID;
                        end
                        S_CHK_ID: begin
                            id_r <= {id_r[23:0], file_data};
                            if (cnt_s == 2'd3) state_r <= S_CHK_LEN;
                        end
                        S_CHK_LEN: begin
                            len_r <= len_full_s;
                            if (cnt_s == 2'd3) begin
                                rem_r   <= len_full_s;
                                off_r   <= '0;
                                bank_r  <= bank_num_s[BANK_BITS-1:0];
                                state_r <= after_len_s;
                            end
                        end
                        S_CHK_DATA, S_CHK_SKIP: begin
                            cnt_r <= 2'd0;
                            rem_r <= rem_r - 32'd1;
                            if (!off_r[BANK_AW]) off_r <= off_r + 1'b1;
                            if (st_s == S_CHK_DATA) begin
                                if (!off_r[BANK_AW]) begin
                                    rom_wr           <= 1'b1;
                                    rom_addr         <= {bank_r, off_r[BANK_AW-1:0]};
                                    rom_data         <= file_data;
                                    payload_checksum <= payload_checksum +
                                                        {{(CSUM_W-8){1'b0}}, file_data};
                                    bank_valid[bank_r] <= 1'b1;
                                    if (!bank_valid[bank_r]) begin
                                        bank_count <= bank_count + {{BANK_BITS{1'b0}}, 1'b1};
                                    end
                                end else begin
                                    warn_oversize <= 1'b1;
                                end
                            end
                            if (rem_r == 32'd1) state_r <= after_body_s;
                        end
                        S_CHK_PAD: begin
                            cnt_r   <= 2'd0;
                            state_r <= S_CHK_ID;
                        end
                        default: begin
                            state_r <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
